pc_sequencer: RTL and testbench



---
 rtl/cpu_defs.sv | 28 ++
 rtl/pc_adder.sv | 21 ++
 rtl/pc_sequencer.sv | 78 +++++++
 tb/tb_pc_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared CPU definitions: FSM state encodings, opcodes and PC step.
// Imported by the sequencer and the next-PC adder.
package cpu_defs;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_EXEC  = 1'b1
  } seq_state_t;

  localparam logic [7:0] OP_ADD   = 8'd0;
  localparam logic [7:0] OP_SUB   = 8'd1;
  localparam logic [7:0] OP_AND   = 8'd2;
  localparam logic [7:0] OP_OR    = 8'd3;
  localparam logic [7:0] OP_J     = 8'd4;
  localparam logic [7:0] OP_BEQ   = 8'd5;
  localparam logic [7:0] OP_MOV   = 8'd6;
  localparam logic [7:0] OP_LOADI = 8'd7;

  localparam logic [31:0] PC_INCR = 32'd4;

  // Word offset -> signed byte displacement.
  function automatic logic [31:0] offset_bytes(
    input logic [7:0] off
  );
    return {{22{off[7]}}, off, 2'b00};
  endfunction

endpackage

// File: rtl/pc_adder.sv
// Combinational next-PC: PC + 4, plus the scaled signed
// offset when a branch or jump is taken.
module pc_adder
  import cpu_defs::*;
(
  input  logic [31:0] pc_i,
  input  logic [7:0]  offset_i,
  input  logic        take_i,
  output logic [31:0] next_pc_o
);

  logic [31:0] seq_pc;
  logic [31:0] disp;

  always_comb begin
    seq_pc    = pc_i + PC_INCR;
    disp      = take_i ? offset_bytes(offset_i) : 32'd0;
    next_pc_o = seq_pc + disp;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Two-state fetch/execute sequencer owning the PC, the
// latched instruction word and the retired-instruction count.
module pc_sequencer
  import cpu_defs::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTR_READDATA,
  input  logic        INSTR_BUSYWAIT,
  input  logic        BEQSIGNAL,
  input  logic        JSIGNAL,
  input  logic        ZERO,
  output logic        INSTR_READ,
  output logic [31:0] PC,
  output logic [31:0] INSTRUCTION,
  output logic        EXEC_VALID,
  output logic [15:0] RETIRED
);

  seq_state_t  state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [15:0] retired_q;

  logic        in_fetch;
  logic        in_exec;
  logic        fetch_done;
  logic        take;
  logic [31:0] next_pc;

  assign in_fetch   = (state_q == S_FETCH);
  assign in_exec    = (state_q == S_EXEC);
  assign fetch_done = in_fetch && !INSTR_BUSYWAIT;

  // Branch inputs only matter while executing.
  assign take = in_exec &&
    (JSIGNAL || (BEQSIGNAL && ZERO));

  pc_adder u_pc_adder (
    .pc_i      (pc_q),
    .offset_i  (instr_q[23:16]),
    .take_i    (take),
    .next_pc_o (next_pc)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH: if (!INSTR_BUSYWAIT) state_d = S_EXEC;
      S_EXEC:  state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_FETCH;
      pc_q      <= 32'd0;
      instr_q   <= 32'd0;
      retired_q <= 16'd0;
    end else begin
      state_q <= state_d;
      if (fetch_done) instr_q <= INSTR_READDATA;
      if (in_exec) begin
        pc_q      <= next_pc;
        retired_q <= retired_q + 16'd1;
      end
    end
  end

  // Reset overrides the state decode.
  assign INSTR_READ  = in_fetch && !RESET;
  assign EXEC_VALID  = in_exec && !RESET;
  assign PC          = pc_q;
  assign INSTRUCTION = instr_q;
  assign RETIRED     = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: fetch/exec flow, busywait,
// branches, reset mid-cycle and PC / retired-count wraps.
module tb_pc_sequencer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] INSTR_READDATA;
  logic        INSTR_BUSYWAIT;
  logic        BEQSIGNAL;
  logic        JSIGNAL;
  logic        ZERO;
  logic        INSTR_READ;
  logic [31:0] PC;
  logic [31:0] INSTRUCTION;
  logic        EXEC_VALID;
  logic [15:0] RETIRED;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_ret = 16'd0;

  pc_sequencer dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .INSTR_READDATA (INSTR_READDATA),
    .INSTR_BUSYWAIT (INSTR_BUSYWAIT),
    .BEQSIGNAL      (BEQSIGNAL),
    .JSIGNAL        (JSIGNAL),
    .ZERO           (ZERO),
    .INSTR_READ     (INSTR_READ),
    .PC             (PC),
    .INSTRUCTION    (INSTRUCTION),
    .EXEC_VALID     (EXEC_VALID),
    .RETIRED        (RETIRED)
  );

  always #5 CLK = ~CLK;

  // Entered at a negedge in FETCH; leaves at the negedge after EXEC.
  task automatic do_instr(
    input logic [31:0] w,
    input logic j, input logic b, input logic z
  );
    INSTR_READDATA = w;
    INSTR_BUSYWAIT = 1'b0;
    @(negedge CLK);
    JSIGNAL = j; BEQSIGNAL = b; ZERO = z;
    @(negedge CLK);
    JSIGNAL = 1'b0; BEQSIGNAL = 1'b0; ZERO = 1'b0;
    exp_ret = exp_ret + 16'd1;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    INSTR_READDATA = 32'hDEADBEEF;
    INSTR_BUSYWAIT = 1'b0;
    BEQSIGNAL = 1'b0; JSIGNAL = 1'b0; ZERO = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if (PC !== 32'h0) begin errors++;
      $display("FAIL rst_pc got %h exp %h", PC, 32'h0); end
    checks++;
    if (INSTRUCTION !== 32'h0) begin errors++;
      $display("FAIL rst_instr got %h exp 0", INSTRUCTION); end
    checks++;
    if (RETIRED !== 16'h0) begin errors++;
      $display("FAIL rst_ret got %h exp 0", RETIRED); end
    checks++;
    if (INSTR_READ !== 1'b0 || EXEC_VALID !== 1'b0) begin errors++;
      $display("FAIL rst_outs got rd=%b ev=%b exp 0 0",
               INSTR_READ, EXEC_VALID); end
    RESET = 1'b0;
  endtask

  task automatic test_basic();
    INSTR_READDATA = 32'h07000005;
    #1;
    checks++;
    if (INSTR_READ !== 1'b1 || PC !== 32'h0) begin errors++;
      $display("FAIL basic_fetch got rd=%b pc=%h exp 1 0",
               INSTR_READ, PC); end
    @(negedge CLK);
    checks++;
    if (EXEC_VALID !== 1'b1 || INSTR_READ !== 1'b0) begin errors++;
      $display("FAIL basic_exec got ev=%b rd=%b exp 1 0",
               EXEC_VALID, INSTR_READ); end
    checks++;
    if (INSTRUCTION !== 32'h07000005) begin errors++;
      $display("FAIL basic_instr got %h exp 07000005", INSTRUCTION); end
    INSTR_READDATA = 32'h11111111;
    @(negedge CLK);
    exp_ret = exp_ret + 16'd1;
    checks++;
    if (PC !== 32'h4 || RETIRED !== 16'd1) begin errors++;
      $display("FAIL basic_next got pc=%h ret=%0d exp 4 1", PC, RETIRED); end
    checks++;
    if (EXEC_VALID !== 1'b0 || INSTR_READ !== 1'b1) begin errors++;
      $display("FAIL basic_back got ev=%b rd=%b exp 0 1",
               EXEC_VALID, INSTR_READ); end
  endtask

  // Busy fetch with branch inputs toggling must not disturb anything.
  task automatic test_busywait();
    INSTR_BUSYWAIT = 1'b1;
    INSTR_READDATA = 32'h06000000;
    JSIGNAL = 1'b1; BEQSIGNAL = 1'b1; ZERO = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++;
      if (PC !== 32'h4 || INSTRUCTION !== 32'h07000005 ||
          EXEC_VALID !== 1'b0 || INSTR_READ !== 1'b1) begin errors++;
        $display("FAIL busy_hold%0d got pc=%h ins=%h ev=%b rd=%b",
                 i, PC, INSTRUCTION, EXEC_VALID, INSTR_READ); end
    end
    INSTR_BUSYWAIT = 1'b0;
    JSIGNAL = 1'b0; BEQSIGNAL = 1'b0; ZERO = 1'b0;
    @(negedge CLK);
    checks++;
    if (EXEC_VALID !== 1'b1 || INSTRUCTION !== 32'h06000000) begin
      errors++;
      $display("FAIL busy_exec got ev=%b ins=%h exp 1 06000000",
               EXEC_VALID, INSTRUCTION); end
    @(negedge CLK);
    exp_ret = exp_ret + 16'd1;
    checks++;
    if (PC !== 32'h8 || RETIRED !== exp_ret) begin errors++;
      $display("FAIL busy_next got pc=%h ret=%0d exp 8 %0d",
               PC, RETIRED, exp_ret); end
  endtask

  task automatic test_beq();
    do_instr(32'h00000000, 1'b0, 1'b0, 1'b0);
    do_instr(32'h01000000, 1'b0, 1'b1, 1'b0);
    checks++;
    if (PC !== 32'h10) begin errors++;
      $display("FAIL seq_pc got %h exp 10", PC); end
    do_instr(32'h05FE0000, 1'b0, 1'b1, 1'b1);
    checks++;
    if (PC !== 32'h0C) begin errors++;
      $display("FAIL beq_taken got %h exp 0c", PC); end
    checks++;
    if (INSTRUCTION !== 32'h05FE0000) begin errors++;
      $display("FAIL beq_hold got %h exp 05fe0000", INSTRUCTION); end
    do_instr(32'h00000000, 1'b0, 1'b0, 1'b0);
    do_instr(32'h05FE0000, 1'b0, 1'b1, 1'b0);
    checks++;
    if (PC !== 32'h14) begin errors++;
      $display("FAIL beq_not got %h exp 14", PC); end
  endtask

  task automatic test_jump();
    for (int i = 0; i < 3; i++)
      do_instr(32'h02000000, 1'b0, 1'b0, 1'b0);
    checks++;
    if (PC !== 32'h20) begin errors++;
      $display("FAIL pre_jump got %h exp 20", PC); end
    do_instr(32'h04030000, 1'b1, 1'b1, 1'b0);
    checks++;
    if (PC !== 32'h30 || RETIRED !== exp_ret) begin errors++;
      $display("FAIL jump got pc=%h ret=%0d exp 30 %0d",
               PC, RETIRED, exp_ret); end
  endtask

  task automatic test_reset_mid();
    INSTR_BUSYWAIT = 1'b1;
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    checks++;
    if (INSTR_READ !== 1'b0 || EXEC_VALID !== 1'b0) begin errors++;
      $display("FAIL rstf_outs got rd=%b ev=%b exp 0 0",
               INSTR_READ, EXEC_VALID); end
    @(negedge CLK);
    checks++;
    if (PC !== 32'h0 || RETIRED !== 16'h0) begin errors++;
      $display("FAIL rstf_state got pc=%h ret=%0d exp 0 0", PC, RETIRED); end
    RESET = 1'b0;
    INSTR_BUSYWAIT = 1'b0;
    INSTR_READDATA = 32'h04050000;
    #1;
    checks++;
    if (INSTR_READ !== 1'b1 || PC !== 32'h0) begin errors++;
      $display("FAIL rstf_resume got rd=%b pc=%h exp 1 0",
               INSTR_READ, PC); end
    @(negedge CLK);
    JSIGNAL = 1'b1;
    RESET = 1'b1;
    #1;
    checks++;
    if (EXEC_VALID !== 1'b0 || INSTR_READ !== 1'b0) begin errors++;
      $display("FAIL rste_outs got ev=%b rd=%b exp 0 0",
               EXEC_VALID, INSTR_READ); end
    @(negedge CLK);
    checks++;
    if (PC !== 32'h0 || RETIRED !== 16'h0 || INSTRUCTION !== 32'h0) begin
      errors++;
      $display("FAIL rste_state got pc=%h ret=%0d ins=%h exp 0 0 0",
               PC, RETIRED, INSTRUCTION); end
    RESET = 1'b0;
    JSIGNAL = 1'b0;
    exp_ret = 16'd0;
    #1;
    checks++;
    if (INSTR_READ !== 1'b1 || PC !== 32'h0) begin errors++;
      $display("FAIL rste_resume got rd=%b pc=%h exp 1 0",
               INSTR_READ, PC); end
  endtask

  task automatic test_pc_wrap();
    do_instr(32'h04800000, 1'b1, 1'b0, 1'b0);
    checks++;
    if (PC !== 32'hFFFFFE04) begin errors++;
      $display("FAIL jump_neg got %h exp fffffe04", PC); end
    do_instr(32'h047D0000, 1'b1, 1'b0, 1'b0);
    checks++;
    if (PC !== 32'hFFFFFFFC) begin errors++;
      $display("FAIL jump_pos got %h exp fffffffc", PC); end
    do_instr(32'h00000000, 1'b0, 1'b1, 1'b0);
    checks++;
    if (PC !== 32'h0 || RETIRED !== exp_ret) begin errors++;
      $display("FAIL pc_wrap got pc=%h ret=%0d exp 0 %0d",
               PC, RETIRED, exp_ret); end
  endtask

  task automatic test_retired_wrap();
    force dut.retired_q = 16'hFFFF;
    #1;
    release dut.retired_q;
    do_instr(32'h00000000, 1'b0, 1'b0, 1'b0);
    checks++;
    if (RETIRED !== 16'h0000) begin errors++;
      $display("FAIL ret_wrap got %h exp 0000", RETIRED); end
    do_instr(32'h00000000, 1'b0, 1'b0, 1'b0);
    checks++;
    if (RETIRED !== 16'h0001 || PC !== 32'h8) begin errors++;
      $display("FAIL ret_after got ret=%h pc=%h exp 0001 8", RETIRED, PC); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_busywait();
    test_beq();
    test_jump();
    test_reset_mid();
    test_pc_wrap();
    test_retired_wrap();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
